// File: rtl/d_cache.sv
// Direct-mapped, one-word-per-line data cache with write-through, no-write-allocate stores.
// Load hits return data in the same cycle; misses and all stores stall the CPU until memory acks.
module d_cache #(
    parameter int ENTRIES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_Wd,
    input  logic [2:0]  i_f3,
    input  logic        i_Wen,
    input  logic        i_MemRead,
    output logic [31:0] o_Data,
    output logic        o_Stall,
    output logic        o_MemReq,
    output logic        o_MemWen,
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWd,
    output logic [3:0]  o_MemBe,
    input  logic [31:0] i_MemData,
    input  logic        i_MemReady
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE
    } state_t;

    state_t             state_q;
    logic               mem_req_q;
    logic               mem_wen_q;

    logic [31:0]        data_q [ENTRIES];
    logic [TAGW-1:0]    tag_q  [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic [IDX-1:0]     idx;
    logic [TAGW-1:0]    tag;
    logic [4:0]         shamt;
    logic [31:0]        line;
    logic               hit;
    logic               fill_ack;
    logic               write_ack;
    logic               line_we;
    logic [3:0]         be;
    logic [31:0]        mem_wd;
    logic [31:0]        line_d;

    // Only the size bits of funct3 matter here; sign extension happens upstream.
    logic               unused_f3;
    assign unused_f3 = i_f3[2];

    assign idx       = i_Addr[IDX+1:2];
    assign tag       = i_Addr[31:IDX+2];
    assign shamt     = {i_Addr[1:0], 3'b000};
    assign line      = data_q[idx];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign fill_ack  = (state_q == S_FILL)  && i_MemReady;
    assign write_ack = (state_q == S_WRITE) && i_MemReady;
    assign line_we   = !i_rst && (fill_ack || (write_ack && hit));
    assign mem_wd    = i_Wd << shamt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        be = 4'b1111;
        case (i_f3[1:0])
            2'b00:   be = 4'b0001 << i_Addr[1:0];
            2'b01:   be = 4'b0011 << i_Addr[1:0];
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        line_d = line;
        if (fill_ack) begin
            line_d = i_MemData;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) line_d[8*b +: 8] = mem_wd[8*b +: 8];
            end
        end
    end

    always_comb begin
        o_Stall = 1'b0;
        case (state_q)
            S_IDLE:  o_Stall = i_Wen || (i_MemRead && !hit);
            default: o_Stall = !i_MemReady;
        endcase
    end

    // The fill word is forwarded on the ack cycle so the CPU can release without a replay.
    assign o_Data    = fill_ack ? (i_MemData >> shamt) : (line >> shamt);
    assign o_MemReq  = mem_req_q;
    assign o_MemWen  = mem_wen_q;
    assign o_MemAddr = {i_Addr[31:2], 2'b00};
    assign o_MemWd   = mem_wd;
    assign o_MemBe   = be;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_wen_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_Wen) begin
                        state_q   <= S_WRITE;
                        mem_req_q <= 1'b1;
                        mem_wen_q <= 1'b1;
                    end else if (i_MemRead && !hit) begin
                        state_q   <= S_FILL;
                        mem_req_q <= 1'b1;
                        mem_wen_q <= 1'b0;
                    end
                end
                S_FILL, S_WRITE: begin
                    if (i_MemReady) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        mem_wen_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    mem_wen_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
        end else if (fill_ack) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // NOTE: line data and tags are deliberately not reset; the valid bits alone make them meaningless.
    always_ff @(posedge i_clk) begin
        if (line_we) begin
            data_q[idx] <= line_d;
            tag_q[idx]  <= tag;
        end
    end

endmodule

// File: doc/d_cache.md
D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 SHALL have parameter ENTRIES, default 32: number of one-word lines; power of two, at least 2; IDX = log2(ENTRIES).
REQ-002 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_Addr, input, 32: CPU byte address.
REQ-005 SHALL have port i_Wd, input, 32: CPU store data, with valid bytes in the LSBs.
REQ-006 SHALL have port i_f3, input, 3: funct3; [1:0] gives size (00 byte, 01 half, 10 word).
REQ-007 SHALL have port i_Wen, input, 1: store request.
REQ-008 SHALL have port i_MemRead, input, 1: load request.
REQ-009 SHALL have port o_Data, output, 32: load word shifted right by 8*i_Addr[1:0].
REQ-010 SHALL have port o_Stall, output, 1: CPU must hold its request; asserted combinationally.
REQ-011 SHALL have port o_MemReq, output, 1: memory transaction request.
REQ-012 SHALL have port o_MemWen, output, 1: the transaction is a write.
REQ-013 SHALL have port o_MemAddr, output, 32: word-aligned address, {i_Addr[31:2],2'b00}.
REQ-014 SHALL have port o_MemWd, output, 32: store data shifted left by 8*i_Addr[1:0].
REQ-015 SHALL have port o_MemBe, output, 4: byte enables.
REQ-016 SHALL have port i_MemData, input, 32: memory read word.
REQ-017 SHALL have port i_MemReady, input, 1: memory acknowledge, valid for one cycle.

Function
REQ-018 SHALL be direct-mapped, one 32-bit word per line.
REQ-019 SHALL index lines with i_Addr[IDX+1:2] and tag with i_Addr[31:IDX+2].
REQ-020 SHALL keep one valid bit per line.
REQ-021 SHALL implement a 3-state FSM with states IDLE, FILL and WRITE.
REQ-022 SHALL, in IDLE on a load hit (valid and tag match), drive o_Stall=0 and o_Data from the line in the same cycle (zero-latency).
REQ-023 SHALL, in IDLE on a load miss, drive o_Stall=1 and go to FILL.
REQ-024 SHALL, in IDLE when i_Wen=1, drive o_Stall=1 and go to WRITE; stores are write-through with no write-allocate.
REQ-025 SHALL give i_Wen priority over i_MemRead when both are 1.
REQ-026 SHALL, in FILL, drive o_MemReq=1 and o_MemWen=0 with o_MemAddr held.
REQ-027 SHALL, in FILL on i_MemReady=1, write i_MemData, tag and valid=1 into the line, drive o_Data from shifted i_MemData, drive o_Stall=0 that cycle, and go to IDLE.
REQ-028 SHALL, in WRITE, drive o_MemReq=1, o_MemWen=1, o_MemBe and o_MemWd.
REQ-029 SHALL, in WRITE on i_MemReady=1, drive o_Stall=0 and go to IDLE.
REQ-030 SHALL, at the i_MemReady=1 edge in WRITE on a hit, merge the enabled bytes into the line; on a miss the line is unchanged.
REQ-031 SHALL derive o_MemBe as: byte 4'b0001<<i_Addr[1:0]; half 4'b0011<<i_Addr[1:0]; word 4'b1111.
REQ-032 SHALL keep o_Stall=1 in FILL and WRITE while i_MemReady=0, with no timeout.
REQ-033 SHALL ignore i_MemReady in IDLE.
REQ-034 SHALL drive o_Stall=0 and o_MemReq=0 in IDLE with no request.
REQ-035 SHALL drive o_MemReq=0 in IDLE; requests are issued from FILL and WRITE only.
REQ-036 SHALL not check misalignment; upstream logic suppresses misaligned requests.
REQ-037 SHALL drive o_Data from the line regardless of hit when no load is active; the value is don't-care.

Reset
REQ-038 SHALL, on i_rst=1 at a clock edge, enter IDLE and clear all valid bits; line data is not cleared.
REQ-039 SHALL drive o_MemReq=0, o_MemWen=0 and o_Stall=0 in the cycle after the reset edge.
REQ-040 SHALL, on reset during FILL or WRITE, abandon the transaction; a late i_MemReady is ignored and no line is updated.

Verification
REQ-041 SHALL be verified by: reset, then LW 0x100 -> o_Stall=1 and o_MemReq=1 at 0x100; i_MemReady=1 with data 0xDEADBEEF after 3 cycles -> o_Data=0xDEADBEEF and o_Stall=0 in the ack cycle; repeat LW -> hit, no o_MemReq.
REQ-042 SHALL be verified by: after REQ-041, SB 0x101 with i_Wd=0x55 -> o_MemBe=4'b0010, o_MemWd=0x00005500, held until ack; then LW 0x100 hits -> 0xDEAD55EF.
REQ-043 SHALL be verified by: with ENTRIES=32, SW 0x200 (miss) -> memory write issued, no allocation; LW 0x200 -> miss/FILL.
REQ-044 SHALL be verified by: load 0x100, then load 0x180 (same index, different tag) -> miss; re-load 0x100 -> miss (evicted).
REQ-045 SHALL be verified by: i_rst=1 during FILL, then i_MemReady=1 -> no line written; next LW of the same address misses.
REQ-046 SHALL be verified by: LH 0x102 hit on 0x12345678 -> o_Data[15:0]=0x1234; i_Wen=1 and i_MemRead=1 together -> WRITE taken.
